// File: rtl/ldst_agu.sv
// ldst_agu: load/store address-generation unit with a single outstanding op.
// Takes one LDUR/STUR micro-op at a time, forms base+offset, optionally
// rejects misaligned addresses, issues one data-memory request with a
// req/ack handshake, and returns a completion record with a valid/ready
// handshake.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   micro-op offer / accept (in_ready only in IDLE)
//   in_is_load          1 = LDUR, 0 = STUR
//   in_base, in_offset  Rn value and sign-extended DAddr9 offset
//   in_wdata, in_rd     store data and register index
//   mem_req/mem_ack     memory request strobe / completion
//   mem_we, mem_addr    write enable and address of the request
//   mem_wdata           store data (0 for loads)
//   mem_rdata           read data, valid with mem_ack
//   out_valid/out_ready completion record offer / accept
//   out_rd, out_data    register index and load data (0 for stores/misaligned)
//   out_is_load         completing op was a load
//   out_misalign        op aborted for misalignment
module ldst_agu #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic [63:0] in_base,
  input  logic [63:0] in_offset,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [63:0] out_data,
  output logic        out_is_load,
  output logic        out_misalign
);

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_addr;
  logic            r_we;
  logic [DW-1:0]   r_wdata;
  logic [RW-1:0]   r_rd;
  logic            r_is_load;
  logic [DW-1:0]   r_data;
  logic            r_misalign;
  logic            r_mem_req;
  logic            r_out_valid;

  logic [DW-1:0]   w_addr;
  logic            w_misalign;

  // Effective address; the carry out of bit 63 is dropped.
  assign w_addr     = DW'(in_base + in_offset);
  assign w_misalign = ALIGN_CHECK && (w_addr[2:0] != 3'd0);

  // Controller: one op in flight, IDLE -> (REQ ->) RESP -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_is_load   <= 1'b0;
      r_data      <= '0;
      r_misalign  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_addr    <= w_addr;
            r_we      <= ~in_is_load;
            r_wdata   <= in_is_load ? '0 : in_wdata;
            r_rd      <= in_rd;
            r_is_load <= in_is_load;
            r_data    <= '0;
            if (w_misalign) begin
              // Misaligned ops bypass memory and complete immediately.
              r_misalign  <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_misalign <= 1'b0;
              r_mem_req  <= 1'b1;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_data      <= r_is_load ? mem_rdata : '0;
            r_mem_req   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_req   <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is a decode of the state register so it is high right after reset.
  assign in_ready     = (r_state == S_IDLE);
  assign mem_req      = r_mem_req;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign out_valid    = r_out_valid;
  assign out_rd       = r_rd;
  assign out_data     = r_data;
  assign out_is_load  = r_is_load;
  assign out_misalign = r_misalign;

endmodule

// File: tb/tb_ldst_agu.sv
// Scoreboard bench for ldst_agu: directed corner cases plus random ops
// checked against an address/memory reference model.
module tb_ldst_agu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic [63:0] in_base;
  logic [63:0] in_offset;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic        out_is_load;
  logic        out_misalign;

  always #5 clk = ~clk;

  ldst_agu #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_is_load(out_is_load), .out_misalign(out_misalign)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        is_load;
    logic        mis;
    int          acc;
    int          lat;
  } cmp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } mreq_t;

  cmp_t        exp_q[$];
  mreq_t       mreq_q[$];
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] dev_mem[logic [63:0]];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_mode = -1;
  int wait_left = -1;
  bit resp_en = 1'b0;
  bit mon_seen = 1'b0;
  bit rdy_force_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Background contents of memory locations never written.
  function automatic logic [63:0] fillv(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  // Memory responder: checks the request every REQ cycle, acks after a delay,
  // and throws spurious acks when no request is pending.
  initial begin
    mreq_t m;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_en || reset) begin
        wait_left = -1;
        continue;
      end
      if (mem_req) begin
        if (mreq_q.size() == 0) begin
          flag("mem_req_unexpected");
          mem_ack = 1'b0;
        end else begin
          m = mreq_q[0];
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", 64'(mem_we), 64'(m.we));
          chk("mem_wdata", mem_wdata, m.wdata);
          if (wait_left < 0) wait_left = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
          if (wait_left == 0) begin
            mem_ack = 1'b1;
            if (m.we) begin
              dev_mem[m.addr] = m.wdata;
              mem_rdata = {$urandom, $urandom};
            end else begin
              mem_rdata = dev_mem.exists(m.addr) ? dev_mem[m.addr] : fillv(m.addr);
            end
            void'(mreq_q.pop_front());
            wait_left = -1;
          end else begin
            wait_left--;
            mem_ack = 1'b0;
            mem_rdata = {$urandom, $urandom};
          end
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Completion monitor: compares every cycle out_valid is high (covers stability).
  initial begin
    cmp_t e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (out_valid) begin
        chk("in_ready_in_resp", 64'(in_ready), 64'(0));
        if (exp_q.size() == 0) begin
          flag("out_valid_unexpected");
        end else begin
          e = exp_q[0];
          if (!mon_seen) begin
            mon_seen = 1'b1;
            if (e.lat >= 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          chk("out_rd", 64'(out_rd), 64'(e.rd));
          chk("out_data", out_data, e.data);
          chk("out_is_load", 64'(out_is_load), 64'(e.is_load));
          chk("out_misalign", 64'(out_misalign), 64'(e.mis));
          if (out_ready) begin
            void'(exp_q.pop_front());
            mon_seen = 1'b0;
          end
        end
      end
    end
  end

  // Downstream ready generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Offer one op, wait for acceptance, and record what the model expects.
  task automatic issue(input bit ld, input logic [63:0] base, input logic [63:0] off,
                       input logic [63:0] wd, input logic [4:0] rd, input int lat_exp);
    logic [63:0] a;
    cmp_t        e;
    mreq_t       m;
    int          guard;
    in_valid = 1'b1;
    in_is_load = ld;
    in_base = base;
    in_offset = off;
    in_wdata = wd;
    in_rd = rd;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 200);
    if (!in_ready) begin
      flag("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    a = base + off;
    e.rd = rd;
    e.is_load = ld;
    e.mis = (a[2:0] != 3'd0);
    e.acc = cyc;
    e.lat = lat_exp;
    if (e.mis) e.data = '0;
    else if (ld) e.data = ref_mem.exists(a) ? ref_mem[a] : fillv(a);
    else begin
      e.data = '0;
      ref_mem[a] = wd;
    end
    if (!e.mis) begin
      m.addr = a;
      m.we = !ld;
      m.wdata = ld ? 64'd0 : wd;
      mreq_q.push_back(m);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_base = {$urandom, $urandom};
    in_offset = {$urandom, $urandom};
    in_wdata = {$urandom, $urandom};
    in_rd = 5'($urandom);
    in_is_load = 1'($urandom);
  endtask

  task automatic drain(input int limit);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || mreq_q.size() != 0) && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || mreq_q.size() != 0) flag("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          guard;
    logic [8:0]  d9;
    logic [63:0] off;
    logic [63:0] tgt;
    bit          ld;
    reset = 1'b1;
    in_valid = 1'b0;
    in_is_load = 1'b0;
    in_base = '0;
    in_offset = '0;
    in_wdata = '0;
    in_rd = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_misalign", 64'(out_misalign), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    resp_en = 1'b1;

    // Load with negative offset, ack on first REQ cycle
    ack_mode = 0;
    ref_mem[64'hFF8] = 64'hDEAD_BEEF;
    dev_mem[64'hFF8] = 64'hDEAD_BEEF;
    issue(1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 5'd3, 2);
    drain(50);

    // Store held for three REQ cycles
    ack_mode = 2;
    issue(1'b0, 64'h2000, 64'h10, 64'h55, 5'd7, 4);
    drain(50);

    // Misaligned load completes without a memory request
    issue(1'b1, 64'h1003, 64'h0, 64'h0, 5'd9, 1);
    drain(50);

    // Address wrap-around
    ack_mode = 0;
    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h0, 5'd11, 2);
    drain(50);

    // Completion stalled for 4 cycles while in_valid pulses
    rdy_force_low = 1'b1;
    issue(1'b1, 64'h3000, 64'h8, 64'h0, 5'd13, 2);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2) == 0;
      in_base = 64'h5000;
      in_offset = 64'h0;
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    rdy_force_low = 1'b0;
    drain(50);

    // Reset mid-REQ abandons the op; later acks are ignored
    ack_mode = 1000;
    issue(1'b1, 64'h6000, 64'h0, 64'h0, 5'd17, -1);
    @(negedge clk);
    chk("midreq_mem_req", 64'(mem_req), 64'(1));
    resp_en = 1'b0;
    mem_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 64'h1234_5678;
    exp_q.delete();
    mreq_q.delete();
    mon_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("postrst_mem_req", 64'(mem_req), 64'(0));
      chk("postrst_out_valid", 64'(out_valid), 64'(0));
      chk("postrst_in_ready", 64'(in_ready), 64'(1));
    end
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    ack_mode = -1;
    resp_en = 1'b1;

    // Random ops over a small address window so loads hit earlier stores
    for (int n = 0; n < 250; n++) begin
      ld = 1'($urandom);
      d9 = 9'($urandom);
      off = {{55{d9[8]}}, d9};
      tgt = 64'h4000 + 64'(8 * $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) tgt = tgt + 64'($urandom_range(1, 7));
      issue(ld, tgt - off, off, {$urandom, $urandom}, 5'($urandom), -1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
